// File: rtl/lzrw1_pkg.sv
// Shared types for the LZRW1 block sequencer.
// Block geometry, byte/block types and the sequencer state encoding.
package lzrw1_pkg;

    localparam int BLOCK_BYTES = 16;

    typedef logic [7:0] byte_t;
    typedef logic [BLOCK_BYTES-1:0][7:0] block_t;

    typedef enum logic [1:0] {
        S_FILL,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_t;

endpackage

// File: rtl/lzrw1_block_packer.sv
// Lane-fill buffer: packs accepted bytes into a 16-lane block and
// pads the tail lanes when the stream ends on a partial block.
module lzrw1_block_packer
    import lzrw1_pkg::*;
#(
    parameter byte_t PAD_BYTE = 8'h00
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   accept,
    input  byte_t  in_byte,
    input  logic   in_last,
    output block_t block,
    output logic   full
);

    logic [3:0] fill_cnt;

    assign full = accept &&
                  (in_last || fill_cnt == 4'(BLOCK_BYTES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            fill_cnt <= '0;
            block    <= {BLOCK_BYTES{PAD_BYTE}};
        end else if (accept) begin
            // Lanes beyond the final byte are padded in the same cycle.
            for (int k = 0; k < BLOCK_BYTES; k++) begin
                if (4'(k) == fill_cnt) begin
                    block[k] <= in_byte;
                end else if (in_last && 4'(k) > fill_cnt) begin
                    block[k] <= PAD_BYTE;
                end
            end
            fill_cnt <= full ? 4'd0 : fill_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/lzrw1_block_sequencer.sv
// Feeds 16-byte blocks to an LZRW1 core, forwards its output bytes,
// counts finished blocks and guards each block with a watchdog.
module lzrw1_block_sequencer
    import lzrw1_pkg::*;
#(
    parameter int    TIMEOUT_CYCLES = 1024,
    parameter byte_t PAD_BYTE       = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  byte_t       in_byte,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output block_t      core_cur_byte,
    output logic        core_valid,
    input  byte_t       core_out_byte,
    input  logic        core_out_valid,
    input  logic        core_finished,
    output byte_t       out_byte,
    output logic        out_valid,
    output logic        done,
    output logic        error,
    output logic [15:0] block_count
);

    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic          last_blk;
    logic          accept;
    logic          full;
    logic          fwd;

    assign in_ready = (state == S_FILL) && !reset;
    assign accept   = in_valid && in_ready;
    assign fwd      = (state == S_WAIT) && core_out_valid;

    lzrw1_block_packer #(
        .PAD_BYTE(PAD_BYTE)
    ) u_packer (
        .clock  (clock),
        .reset  (reset),
        .accept (accept),
        .in_byte(in_byte),
        .in_last(in_last),
        .block  (core_cur_byte),
        .full   (full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_FILL;
            wait_cnt    <= '0;
            last_blk    <= 1'b0;
            core_valid  <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            block_count <= '0;
            out_valid   <= 1'b0;
            out_byte    <= '0;
        end else begin
            core_valid <= 1'b0;
            done       <= 1'b0;
            out_valid  <= fwd;
            if (fwd) begin
                out_byte <= core_out_byte;
            end
            unique case (state)
                S_FILL: begin
                    if (full) begin
                        state      <= S_ISSUE;
                        core_valid <= 1'b1;
                        if (in_last) begin
                            last_blk <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    // Finish wins over a coincident watchdog expiry.
                    if (core_finished) begin
                        block_count <= block_count + 16'd1;
                        if (last_blk) begin
                            state <= S_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= S_FILL;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        error <= 1'b1;
                        state <= S_FINISH;
                        done  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_FINISH: begin
                    last_blk <= 1'b0;
                    state    <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lzrw1_block_sequencer.sv
// Randomized self-checking bench for lzrw1_block_sequencer
// against a stream-chunking reference model.
module tb_lzrw1_block_sequencer;

    localparam int          TO  = 8;
    localparam logic [7:0]  PAD = 8'h00;

    logic               clock = 1'b0;
    logic               reset;
    logic [7:0]         in_byte;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic [15:0][7:0]   core_cur_byte;
    logic               core_valid;
    logic [7:0]         core_out_byte;
    logic               core_out_valid;
    logic               core_finished;
    logic [7:0]         out_byte;
    logic               out_valid;
    logic               done;
    logic               error;
    logic [15:0]        block_count;

    lzrw1_block_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .PAD_BYTE(PAD)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_byte       (in_byte),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .core_cur_byte (core_cur_byte),
        .core_valid    (core_valid),
        .core_out_byte (core_out_byte),
        .core_out_valid(core_out_valid),
        .core_finished (core_finished),
        .out_byte      (out_byte),
        .out_valid     (out_valid),
        .done          (done),
        .error         (error),
        .block_count   (block_count)
    );

    always #5 clock = ~clock;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         bc_exp = 0;
    logic       err_exp = 1'b0;
    logic [7:0] blk [16];
    logic [7:0] stream [$];

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic last);
        int gap;
        int guard;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            in_valid       = 1'b0;
            core_out_valid = 1'($urandom_range(0, 1));
            core_out_byte  = 8'($urandom);
            core_finished  = 1'($urandom_range(0, 1));
            tick();
            check("fill_out_valid_ignored", 128'(out_valid), 128'(0));
            check("fill_finish_ignored", 128'(block_count), 128'(16'(bc_exp)));
        end
        core_out_valid = 1'b0;
        core_finished  = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (guard == 20) check("in_ready_wait", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_block(input int n, input bit last,
                              input int resp, input bit finish);
        logic [15:0][7:0] e;
        logic [7:0]       d;
        for (int k = 0; k < 16; k++) e[k] = (k < n) ? blk[k] : PAD;
        for (int i = 0; i < n; i++) push_byte(blk[i], last && i == n - 1);
        check("issue_core_valid", 128'(core_valid), 128'(1));
        check("issue_in_ready", 128'(in_ready), 128'(0));
        check("issue_block", 128'(core_cur_byte), 128'(e));
        tick();
        check("wait_core_valid", 128'(core_valid), 128'(0));
        if (finish) begin
            if (resp == 0) begin
                core_finished = 1'b1;
                tick();
            end
            for (int j = 0; j < resp; j++) begin
                d = 8'($urandom);
                core_out_valid = 1'b1;
                core_out_byte  = d;
                core_finished  = (j == resp - 1);
                tick();
                check("fwd_valid", 128'(out_valid), 128'(1));
                check("fwd_byte", 128'(out_byte), 128'(d));
            end
            core_out_valid = 1'b0;
            core_finished  = 1'b0;
            bc_exp++;
        end else begin
            repeat (7) tick();
            check("pre_timeout_error", 128'(error), 128'(err_exp));
            check("pre_timeout_done", 128'(done), 128'(0));
            tick();
            err_exp = 1'b1;
            check("timeout_error", 128'(error), 128'(1));
        end
        check("block_count", 128'(block_count), 128'(16'(bc_exp)));
        check("block_stable", 128'(core_cur_byte), 128'(e));
        if (last || !finish) begin
            check("done_pulse", 128'(done), 128'(1));
            check("finish_in_ready", 128'(in_ready), 128'(0));
            tick();
        end
        check("done_low", 128'(done), 128'(0));
        check("back_to_fill", 128'(in_ready), 128'(1));
        check("error_flag", 128'(error), 128'(err_exp));
    endtask

    task automatic send_stream(input int len);
        int off;
        int n;
        stream.delete();
        for (int i = 0; i < len; i++) stream.push_back(8'($urandom));
        off = 0;
        while (off < len) begin
            n = (len - off > 16) ? 16 : len - off;
            for (int i = 0; i < n; i++) blk[i] = stream[off + i];
            send_block(n, off + n == len, $urandom_range(0, 5), 1'b1);
            off += n;
        end
    endtask

    task automatic check_reset_values;
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_core_valid", 128'(core_valid), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_error", 128'(error), 128'(0));
        check("rst_block_count", 128'(block_count), 128'(0));
        check("rst_block", 128'(core_cur_byte), {16{PAD}});
        check("rst_out_byte", 128'(out_byte), 128'(0));
    endtask

    initial begin
        reset          = 1'b1;
        in_byte        = '0;
        in_valid       = 1'b0;
        in_last        = 1'b0;
        core_out_byte  = '0;
        core_out_valid = 1'b0;
        core_finished  = 1'b0;
        tick();
        tick();
        check_reset_values();
        reset = 1'b0;

        for (int i = 0; i < 16; i++) blk[i] = 8'(i);
        send_block(16, 1'b1, 3, 1'b1);

        for (int i = 0; i < 5; i++) blk[i] = 8'hA1 + 8'(i);
        send_block(5, 1'b1, 3, 1'b1);

        repeat (6) send_stream($urandom_range(1, 40));

        for (int i = 0; i < 3; i++) blk[i] = 8'($urandom);
        send_block(3, 1'b1, 0, 1'b0);
        send_stream(20);

        for (int i = 0; i < 7; i++) push_byte(8'($urandom), 1'b0);
        reset = 1'b1;
        tick();
        check_reset_values();
        reset = 1'b0;
        bc_exp  = 0;
        err_exp = 1'b0;
        tick();
        check("post_reset_core_valid", 128'(core_valid), 128'(0));
        check("post_reset_done", 128'(done), 128'(0));
        for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
        send_block(16, 1'b1, 2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lzrw1_block_sequencer.md
LZRW1_BLOCK_SEQUENCER -- requirements
Module: lzrw1_block_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum WAIT-state cycles before error.
REQ-002 SHALL have parameter PAD_BYTE, default 8'h00: fill value for unused lanes of a partial block.
REQ-003 SHALL have port clock  input  1  the only clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_byte  input  8  source byte.
REQ-006 SHALL have port in_valid  input  1  in_byte is valid.
REQ-007 SHALL have port in_last  input  1  final byte of the stream; qualified by in_valid.
REQ-008 SHALL have port in_ready  output  1  sequencer accepts a byte this cycle.
REQ-009 SHALL have port core_cur_byte  output  [15:0][7:0]  block to the core; lane k holds the k-th accepted byte.
REQ-010 SHALL have port core_valid  output  1  one-cycle block-issue strobe to the core.
REQ-011 SHALL have port core_out_byte  input  8  core decompressed_byte.
REQ-012 SHALL have port core_out_valid  input  1  core out_valid.
REQ-013 SHALL have port core_finished  input  1  core finished_cycle.
REQ-014 SHALL have port out_byte  output  8  registered copy of core_out_byte.
REQ-015 SHALL have port out_valid  output  1  out_byte valid.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the last block finishes.
REQ-017 SHALL have port error  output  1  sticky watchdog timeout flag.
REQ-018 SHALL have port block_count  output  16  blocks completed since reset; wraps at 16'hFFFF->0.

Function
REQ-019 SHALL implement FSM states FILL, ISSUE, WAIT, FINISH.
REQ-020 in FILL: in_ready=1; an accepted byte (in_valid&in_ready) SHALL be written to lane fill_cnt and fill_cnt (0..15) incremented.
REQ-021 FILL->ISSUE SHALL occur on acceptance of the 16th byte, or of any byte with in_last=1; fill_cnt returns to 0.
REQ-022 on in_last with fewer than 16 bytes, lanes fill_cnt+1..15 SHALL be set to PAD_BYTE and last_blk latched; in_last on the 16th byte latches last_blk with no padding.
REQ-023 in ISSUE: core_valid=1 for exactly one cycle, in_ready=0; next state WAIT; wait_cnt cleared.
REQ-024 core_cur_byte SHALL remain stable from ISSUE until the first byte of the next block is accepted.
REQ-025 in WAIT: each core_out_valid SHALL produce out_valid/out_byte exactly one cycle later (latency 1); core_out_valid outside WAIT SHALL be ignored.
REQ-026 in WAIT on core_finished: block_count increments; next state FINISH if last_blk, else FILL.
REQ-027 core_out_valid and core_finished in the same cycle SHALL both be honoured (byte forwarded, then transition).
REQ-028 core_finished outside WAIT SHALL be ignored.
REQ-029 wait_cnt SHALL increment each WAIT cycle; reaching TIMEOUT_CYCLES-1 without core_finished SHALL set error and go to FINISH without incrementing block_count.
REQ-030 FINISH SHALL pulse done for one cycle, clear last_blk, and return to FILL.
REQ-031 error SHALL remain set until reset; operation continues after error.

Reset
REQ-032 while reset=1: state=FILL, in_ready=0, core_valid=0, out_valid=0, done=0, error=0, block_count=0, fill_cnt=0, wait_cnt=0, last_blk=0, core_cur_byte=all PAD_BYTE, out_byte=0.
REQ-033 reset asserted mid-block (any state) SHALL discard the partial block with no core_valid, done or out_valid afterwards.

Structure
REQ-034 package lzrw1_pkg SHALL hold BLOCK_BYTES=16, byte_t (logic [7:0]), block_t ([15:0][7:0]) and the state enum.
REQ-035 lane-fill buffer with fill_cnt and padding SHALL be sub-module lzrw1_block_packer; FSM, watchdog and forwarding stay in the top.

Verification
REQ-036 16 bytes 0x00..0x0F, in_last on 16th -> one core_valid pulse, core_cur_byte lane k = k; after core_finished, done pulse, block_count=1.
REQ-037 5 bytes 0xA1..0xA5 with in_last on 5th -> lanes 0..4 = A1..A5, lanes 5..15 = 0x00; in_ready=0 until FINISH.
REQ-038 core_out_valid for 3 cycles with bytes 0x41,0x42,0x43, core_finished on the 3rd -> out_valid 3 cycles, each one cycle later, same data; state returns to FILL.
REQ-039 TIMEOUT_CYCLES=8, core never finishes -> error=1 after 8 WAIT cycles, done pulse, block_count unchanged, error held until reset.
REQ-040 reset asserted after 7 bytes accepted -> next cycle all outputs at reset values; then 16 new bytes issue with lane 0 = first post-reset byte.
